// File: rtl/sram_bus_arbiter_if.sv
// CPU-side and RAM1-pin signals of the SRAM bus arbiter.
// slave = the arbiter, master = the IF/MEM stages and the SRAM pins it talks to.
interface sram_bus_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        stall;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_i;
  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dq_i,
    output if_rdata, if_ack, d_rdata, d_ack, stall,
           ram_addr, ram_dq_o, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dq_i,
    input  if_rdata, if_ack, d_rdata, d_ack, stall,
           ram_addr, ram_dq_o, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares the RAM1 SRAM between fetch and data ports: data has priority, fetch
// is guaranteed one grant after STARVE_LIMIT consecutive data grants.
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  sram_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, WR_C, ACK} state_t;

  state_t      state, state_next;
  logic        grant_d, grant_f;
  logic        owner_d;
  logic [2:0]  starve_cnt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && (!bus.if_req || int'(starve_cnt) < STARVE_LIMIT)) begin
          grant_d    = 1'b1;
          state_next = bus.d_we ? WR_A : RD_A;
        end else if (bus.if_req) begin
          grant_f    = 1'b1;
          state_next = RD_A;
        end
      end
      RD_A:    state_next = RD_B;
      RD_B:    state_next = ACK;
      WR_A:    state_next = WR_B;
      WR_B:    state_next = WR_C;
      WR_C:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Strobes and acks are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d      <= 1'b0;
      starve_cnt   <= '0;
      bus.ram_addr <= '0;
      bus.ram_dq_o <= '0;
      bus.ram_en_n <= 1'b1;
      bus.ram_oe_n <= 1'b1;
      bus.ram_we_n <= 1'b1;
      bus.ram_dq_oe <= 1'b0;
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
    end else begin
      if (grant_d) begin
        owner_d      <= 1'b1;
        bus.ram_addr <= {2'b00, bus.d_addr};
        if (bus.d_we) bus.ram_dq_o <= bus.d_wdata;
        if (!bus.if_req)            starve_cnt <= '0;
        else if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
      end else if (grant_f) begin
        owner_d      <= 1'b0;
        bus.ram_addr <= {2'b00, bus.if_addr};
        starve_cnt   <= '0;
      end

      bus.ram_en_n  <= !(state_next inside {RD_A, RD_B, WR_A, WR_B, WR_C});
      bus.ram_oe_n  <= !(state_next inside {RD_A, RD_B});
      bus.ram_we_n  <= (state_next != WR_B);
      bus.ram_dq_oe <= (state_next inside {WR_A, WR_B, WR_C});
      bus.if_ack    <= (state_next == ACK) && !owner_d;
      bus.d_ack     <= (state_next == ACK) &&  owner_d;

      if (state == RD_B) begin
        if (owner_d) bus.d_rdata  <= bus.ram_dq_i;
        else         bus.if_rdata <= bus.ram_dq_i;
      end
    end
  end

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Arbitrates the single 16-bit RAM1 SRAM bus between the instruction-fetch port and the data-memory port of the 16-bit CPU. It serialises accesses into fixed multi-cycle SRAM read and write sequences and gives the data port priority, with a starvation guard for fetch. It drives the SRAM control strobes and a pipeline `stall` signal. It sits between the IF/MEM stages and the board-level RAM1 pins; the top level builds the tri-state from `ram_dq_o`/`ram_dq_oe`.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants allowed while fetch is pending; after that, fetch wins one grant.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch request, level; held until `if_ack`.
- `if_addr` input 16: fetch word address.
- `if_rdata` output 16: fetched word; valid while `if_ack`=1.
- `if_ack` output 1: one-cycle completion pulse for fetch.
- `d_req` input 1: data request, level; held until `d_ack`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input 16: data word address.
- `d_wdata` input 16: write data.
- `d_rdata` output 16: read data; valid while `d_ack`=1.
- `d_ack` output 1: one-cycle completion pulse for data.
- `stall` output 1: combinational; equals `(if_req & ~if_ack) | (d_req & ~d_ack)`.
- `ram_addr` output 18: SRAM address, `{2'b00, latched addr}`.
- `ram_dq_o` output 16: SRAM write data.
- `ram_dq_oe` output 1: 1 = drive the SRAM data bus.
- `ram_dq_i` input 16: SRAM data bus as read back.
- `ram_en_n`, `ram_oe_n`, `ram_we_n` output 1 each: SRAM chip enable, output enable and write enable, all active-low.

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, WR_C, ACK.
- **IDLE arbitration**, evaluated on each edge while in IDLE:
  - If `d_req`=1 and (`if_req`=0 or `starve_cnt` < `STARVE_LIMIT`), grant data.
  - Else if `if_req`=1, grant fetch.
  - Else stay in IDLE.
- **Grant latching:** on grant, the address, `d_we`, `d_wdata` and the owner are latched. Requester inputs are ignored until ACK.
- **Next state after grant:** a fetch or a data read goes to RD_A; a data write goes to WR_A.
- **`starve_cnt`** (3 bits, saturating):
  - Increments on a data grant while `if_req`=1.
  - Clears on a fetch grant.
  - Clears on a data grant while `if_req`=0.
- **RD_A, RD_B:** `ram_en_n`=0, `ram_oe_n`=0, `ram_we_n`=1, `ram_dq_oe`=0. At the RD_B→ACK edge, `ram_dq_i` is captured into the owner's rdata register.
- **WR_A:** `ram_en_n`=0, `ram_oe_n`=1, `ram_we_n`=1, `ram_dq_oe`=1, `ram_dq_o`=latched data.
- **WR_B:** as WR_A, but `ram_we_n`=0.
- **WR_C:** as WR_A (`ram_we_n`=1), with data and address held. This gives hold time after the rising edge of WE.
- **ACK:**
  - The owner's ack is 1; all strobes are inactive and `ram_dq_oe`=0.
  - No arbitration happens in ACK; the next edge always goes to IDLE.
  - A request still high in IDLE afterwards is a new request, which permits back-to-back accesses.
- **Outside an access:** in IDLE and ACK, `ram_addr` holds its last value. `if_rdata` and `d_rdata` hold their last captured value at all times.
- **Mid-access changes:** a requester that drops `req` mid-access does not abort the access; it completes and the ack still pulses.
- **Simultaneous requests:** when `if_req` and `d_req` rise in the same cycle, data wins unless the starvation guard applies.

## Timing
- **Read latency:** request sampled in IDLE at edge e0; RD_A at e1; RD_B at e2; ACK, with rdata valid, at e3; IDLE at e4. Ack is 3 cycles after grant.
- **Write latency:** WR_A at e1, WR_B at e2, WR_C at e3, ACK at e4, IDLE at e5.
- **WE pulse:** `ram_we_n` is low for exactly one clock. Address and data are stable one cycle before and one cycle after the pulse.
- **Throughput:** minimum back-to-back read period is 4 cycles; write period is 5 cycles.
- **Reset values** (asynchronous while `rst`=0):
  - State IDLE, `starve_cnt`=0.
  - `ram_en_n`=`ram_oe_n`=`ram_we_n`=1, `ram_dq_oe`=0.
  - `ram_addr`=0, `ram_dq_o`=0.
  - `if_ack`=`d_ack`=0, `if_rdata`=`d_rdata`=0.
- **Reset mid-access:** strobes deassert immediately and no ack is issued. After `rst` rises, the first arbitration happens at the first rising edge.
- All outputs except `stall` are registered.

## Test plan
- **Reset:** hold `rst`=0 → strobes=1, `ram_dq_oe`=0, acks=0, rdatas=0; release → IDLE with no bus activity.
- **Single fetch:** `if_req`=1, `if_addr`=16'h0010, SRAM returns 16'h6A05 → `ram_addr`=18'h00010 with `en_n`/`oe_n` low for 2 cycles; `if_ack`=1 and `if_rdata`=16'h6A05 at grant+3; `stall` is high until then.
- **Single write:** `d_req`=1, `d_we`=1, `d_addr`=16'h4000, `d_wdata`=16'hBEEF → `ram_dq_oe`=1 for WR_A–WR_C; `ram_we_n` low only in WR_B; `d_ack` at grant+4; SRAM model holds 16'hBEEF at 18'h04000.
- **Conflict:** `if_req` and `d_req` (read of 16'h8000) rise together → data served first (`d_ack` at +3); fetch granted at the next IDLE; `if_ack` at +7 relative to the first grant.
- **Starvation:** `if_req` held while `d_req` is re-asserted continuously with `STARVE_LIMIT`=4 → grant order is D,D,D,D,F,D…; `starve_cnt` clears after the fetch grant.
- **Reset mid-write:** assert `rst`=0 during WR_B → `ram_we_n`=1 and `ram_dq_oe`=0 immediately; no `d_ack`; after release, a new read completes normally in 3 cycles.
